// File: rtl/dwt_coeff_serializer_if.sv
// Bus between the 2D DWT core, the coefficient serializer and the entropy coder.
// The master side offers coefficient blocks and the ready strobe; the slave side is the serializer.
interface dwt_coeff_serializer_if #(
    parameter int COEF_W = 8
);
    logic                  dwt_valid;
    logic [8*COEF_W-1:0]   coef_row0;
    logic [8*COEF_W-1:0]   coef_row1;
    logic [8*COEF_W-1:0]   coef_row2;
    logic [8*COEF_W-1:0]   coef_row3;
    logic [8*COEF_W-1:0]   coef_row4;
    logic [8*COEF_W-1:0]   coef_row5;
    logic [8*COEF_W-1:0]   coef_row6;
    logic [8*COEF_W-1:0]   coef_row7;
    logic [COEF_W-1:0]     coef_data;
    logic                  coef_valid;
    logic                  coef_ready;
    logic [5:0]            coef_idx;
    logic                  coef_last;
    logic                  blk_busy;
    logic                  overflow;

    modport master (
        output dwt_valid, coef_row0, coef_row1, coef_row2, coef_row3,
               coef_row4, coef_row5, coef_row6, coef_row7, coef_ready,
        input  coef_data, coef_valid, coef_idx, coef_last, blk_busy, overflow
    );

    modport slave (
        input  dwt_valid, coef_row0, coef_row1, coef_row2, coef_row3,
               coef_row4, coef_row5, coef_row6, coef_row7, coef_ready,
        output coef_data, coef_valid, coef_idx, coef_last, blk_busy, overflow
    );
endinterface

// File: rtl/dwt_coeff_serializer.sv
// Captures thresholded 8x8 DWT coefficient blocks into a two-bank ping-pong buffer
// and streams them out one coefficient per cycle over valid/ready.
module dwt_coeff_serializer #(
    parameter int COEF_W = 8,
    parameter int THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dwt_coeff_serializer_if.slave bus
);
    localparam int BLK = 64;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    logic [8*COEF_W-1:0] rows      [8];
    logic [COEF_W-1:0]   cap_val   [BLK];
    logic [COEF_W-1:0]   bank_mem  [2][BLK];

    state_t     state, state_nxt;
    logic [5:0] idx, idx_nxt;
    logic [1:0] bank_full, full_nxt;
    logic       wr_ptr, wr_ptr_nxt;
    logic       rd_ptr, rd_ptr_nxt;
    logic       busy, ovf;
    logic       fire, drain, cap, drop;

    function automatic logic [COEF_W-1:0] thresh(input logic [COEF_W-1:0] v);
        int sv;
        sv = int'($signed(v));
        if ((sv > -THRESH) && (sv < THRESH)) return '0;
        return v;
    endfunction

    assign rows[0] = bus.coef_row0;
    assign rows[1] = bus.coef_row1;
    assign rows[2] = bus.coef_row2;
    assign rows[3] = bus.coef_row3;
    assign rows[4] = bus.coef_row4;
    assign rows[5] = bus.coef_row5;
    assign rows[6] = bus.coef_row6;
    assign rows[7] = bus.coef_row7;

    // Buffer index {row, lane} matches the streaming order.
    for (genvar g = 0; g < BLK; g++) begin : g_thresh
        assign cap_val[g] = thresh(rows[g/8][(g%8)*COEF_W +: COEF_W]);
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        fire       = (state == S_STREAM) && bus.coef_ready;
        drain      = fire && (idx == 6'd63);
        // A bank being drained this cycle still counts as full for capture.
        cap        = bus.dwt_valid && !bank_full[wr_ptr];
        drop       = bus.dwt_valid &&  bank_full[wr_ptr];

        full_nxt   = bank_full;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        state_nxt  = state;
        idx_nxt    = idx;

        if (drain) begin
            full_nxt[rd_ptr] = 1'b0;
            rd_ptr_nxt       = ~rd_ptr;
        end
        if (cap) begin
            full_nxt[wr_ptr] = 1'b1;
            wr_ptr_nxt       = ~wr_ptr;
        end

        // Decisions look at next-cycle bank flags so a fresh capture starts without a bubble.
        case (state)
            S_IDLE: begin
                idx_nxt = '0;
                if (full_nxt[rd_ptr]) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (fire) begin
                    if (idx == 6'd63) begin
                        idx_nxt   = '0;
                        state_nxt = full_nxt[rd_ptr_nxt] ? S_STREAM : S_IDLE;
                    end else begin
                        idx_nxt = idx + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            bank_full <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            idx       <= idx_nxt;
            bank_full <= full_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            busy      <= |full_nxt;
            if (drop) ovf <= 1'b1;
        end
    end

    // NOTE: bank storage has no reset; the full flags alone decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (cap) bank_mem[wr_ptr] <= cap_val;
    end

    assign bus.coef_valid = (state == S_STREAM);
    assign bus.coef_data  = (state == S_STREAM) ? bank_mem[rd_ptr][idx] : '0;
    assign bus.coef_idx   = idx;
    assign bus.coef_last  = (state == S_STREAM) && (idx == 6'd63);
    assign bus.blk_busy   = busy;
    assign bus.overflow   = ovf;
endmodule
